stopwatch_mmss: RTL and testbench
=================================

Name: stopwatch_mmss

Overview:
- Parametrised MM:SS stopwatch core with run/pause, synchronous clear, and a field-adjust mode.
- Drives a 4-digit multiplexed active-low seven-segment display.
- Successor to the fixed-divider stopwatch:
  - tick dividers and minute range are parameters;
  - all timing uses single-cycle strobes on one clock; there are no derived clocks.
- Sits between the debounced button/switch conditioning and the board `an`/`seg` pins.

Parameters:
- TICK_DIV, 100000000: clk cycles per counted second.
- ADJ_DIV, 50000000: clk cycles per adjust increment (2 Hz).
- BLINK_DIV, 25000000: clk cycles per blink phase toggle.
- SCAN_DIV, 100000: clk cycles per digit-scan advance.
- MAX_MIN, 99: highest minute value, 1..99; count wraps MAX_MIN:59 -> 00:00.

Ports:
- clk, in, 1: system clock, 100 MHz.
- rst_n, in, 1: asynchronous active-low reset.
- pause_pulse, in, 1: one-cycle debounced pulse; toggles run/pause.
- clear_pulse, in, 1: one-cycle debounced pulse; zeroes the time.
- adj, in, 1: level; 1 = adjust mode.
- sel, in, 1: level; 0 = adjust minutes, 1 = adjust seconds.
- an, out, 4: digit enables, active-low, one-hot-low.
- seg, out, 8: segments {dp,g..a}, active-low.
- minutes, out, 7: current minutes, binary.
- seconds, out, 6: current seconds, binary, 0..59.

Behaviour:
- Reset values (rst_n low): state=RUN, minutes=0, seconds=0, all prescalers=0, digit index=0, blink phase=1, an=4'b1111, seg=8'hFF.
- Strobes: each divider counts 0..DIV-1 and asserts its strobe for exactly 1 cycle when the count reaches DIV-1.
- State machine, evaluated each clk:
  - RUN -> PAUSED on pause_pulse.
  - PAUSED -> RUN on pause_pulse.
  - RUN or PAUSED -> ADJUST while adj=1.
  - ADJUST -> PAUSED when adj falls.
  - pause_pulse is ignored in ADJUST.
- RUN, on tick strobe:
  - seconds+1.
  - At 59: seconds=0 and minutes+1.
  - At MAX_MIN:59: wrap to 0:0.
- PAUSED: time holds; the tick prescaler is held at 0, so resume yields a full TICK_DIV period before the next increment.
- ADJUST:
  - Tick prescaler held at 0.
  - On adj strobe, increment the selected field only, with no carry: seconds 59->0, minutes MAX_MIN->0.
  - The adj prescaler is held at 0 outside ADJUST, so the first increment occurs ADJ_DIV cycles after entry.
- clear_pulse: minutes=0, seconds=0, tick prescaler=0 in the same cycle. State is unchanged. It wins over a tick or adj strobe in the same cycle.
- Simultaneous pause_pulse and clear_pulse: both take effect.
- Display scan:
  - Digit index 0..3 advances on scan strobe; 3 wraps to 0.
  - Digit 0 = sec ones, 1 = sec tens, 2 = min ones, 3 = min tens.
  - Values are derived with div/mod by 10 on the registered fields.
  - an and seg are registered: 1 cycle latency from a digit index or time change.
- Blink: phase toggles on blink strobe, only while in ADJUST; it is forced to 1 outside ADJUST. In ADJUST with phase=0, the selected field's two digits drive seg=8'hFF; an keeps scanning.
- Digit encoding: standard active-low 0-9 with dp off. Non-decimal values give 8'hFF (unreachable).

Optional Feature:
- STOPWATCH_COLON_EN defined:
  - seg[7] (dp) is driven low on digit 2 during the first half of each second in RUN, i.e. tick prescaler < TICK_DIV/2.
  - dp is steady low on digit 2 in PAUSED and ADJUST.
  - Otherwise dp is high.
- STOPWATCH_COLON_EN undefined: seg[7]=1 always; no extra logic.

Decomposition:
- stopwatch_pkg:
  - state enum {RUN, PAUSED, ADJUST};
  - SEG_BLANK=8'hFF;
  - 10-entry digit-to-segment constant table;
  - digit-index constants.
- Sub-module strobe_div (parameter DIV; ports clk, rst_n, hold, strobe), instantiated 4 times: tick, adj, blink, scan.
- Decode, time counters and FSM stay in stopwatch_mmss.

Test Plan (TICK_DIV=10, ADJ_DIV=5, BLINK_DIV=3, SCAN_DIV=4, MAX_MIN=2):
1. Release reset, run 10 cycles -> seconds=1 on the 10th cycle. Run 600 cycles -> 01:00. Run to 02:59 plus 1 tick -> 00:00.
2. At 00:03 pulse pause, wait 50 cycles -> time holds 00:03. Pulse pause -> 00:04 exactly 10 cycles later.
3. adj=1, sel=1, seconds=58, wait 10 cycles -> 00:00 with minutes unchanged. sel=0 at minutes=2 plus one adj strobe -> minutes=0.
4. In ADJUST with sel=0 -> digits 2/3 show seg=8'hFF on alternate 3-cycle phases; digits 0/1 never blank. Drop adj -> state PAUSED, no blanking.
5. clear_pulse coincident with a tick strobe at 01:59 -> 00:00, never 02:00. Assert rst_n=0 mid-scan -> an=4'b1111, seg=8'hFF immediately, without waiting for a clk edge.
6. At 01:23 run scan for 16 cycles -> an sequence 1110, 1101, 1011, 0111 with seg 8'hB0, 8'hA4, 8'hF9, 8'hC0, each lagging its index by 1 cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding, digit indices and seven-segment glyphs.
package stopwatch_pkg;
  typedef enum logic [1:0] {RUN, PAUSED, ADJUST} state_t;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;
  localparam logic [7:0] SEG_LUT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  function automatic logic [7:0] seg_of(input logic [3:0] v);
    return (v > 4'd9) ? SEG_BLANK : SEG_LUT[v];
  endfunction
endpackage

// File: rtl/strobe_div.sv
// strobe_div: counts 0..DIV-1 and pulses strobe for one cycle at DIV-1; hold parks it at 0.
module strobe_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic hold,
  output logic strobe
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] cnt;
  assign strobe = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= (hold || strobe) ? '0 : cnt + W'(1);
endmodule

// File: rtl/stopwatch_mmss.sv
// stopwatch_mmss: MM:SS stopwatch with run/pause/clear/adjust and 4-digit muxed display.
// Optional STOPWATCH_COLON_EN drives the digit-2 dp as a colon.
module stopwatch_mmss
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = 100000000,
  parameter int ADJ_DIV   = 50000000,
  parameter int BLINK_DIV = 25000000,
  parameter int SCAN_DIV  = 100000,
  parameter int MAX_MIN   = 99
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pause_pulse,
  input  logic       clear_pulse,
  input  logic       adj,
  input  logic       sel,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic [6:0] minutes,
  output logic [5:0] seconds
);
  state_t state, state_nx;
  logic tick, adj_stb, blink_stb, scan_stb, phase, blank, dp;
  logic [1:0] idx;
  logic [3:0] dval;
  logic [7:0] glyph;
  logic [6:0] min_nx;
  logic [5:0] sec_nx;
  strobe_div #(.DIV(TICK_DIV)) u_tick (
    .clk(clk), .rst_n(rst_n), .hold(state != RUN || clear_pulse), .strobe(tick)
  );
  strobe_div #(.DIV(ADJ_DIV)) u_adj (
    .clk(clk), .rst_n(rst_n), .hold(state != ADJUST), .strobe(adj_stb)
  );
  strobe_div #(.DIV(BLINK_DIV)) u_blink (
    .clk(clk), .rst_n(rst_n), .hold(1'b0), .strobe(blink_stb)
  );
  strobe_div #(.DIV(SCAN_DIV)) u_scan (
    .clk(clk), .rst_n(rst_n), .hold(1'b0), .strobe(scan_stb)
  );
  always_comb begin
    state_nx = state;
    if (state == ADJUST) state_nx = adj ? ADJUST : PAUSED;
    else if (adj) state_nx = ADJUST;
    else if (pause_pulse) state_nx = (state == RUN) ? PAUSED : RUN;
  end
  // clear beats any strobe; adjust increments never carry between fields
  always_comb begin
    min_nx = minutes;
    sec_nx = seconds;
    if (clear_pulse) begin
      min_nx = '0;
      sec_nx = '0;
    end else if (state == RUN && tick) begin
      sec_nx = (seconds == 6'd59) ? '0 : seconds + 6'd1;
      if (seconds == 6'd59) min_nx = (minutes == 7'(MAX_MIN)) ? '0 : minutes + 7'd1;
    end else if (state == ADJUST && adj_stb) begin
      if (sel) sec_nx = (seconds == 6'd59) ? '0 : seconds + 6'd1;
      else min_nx = (minutes == 7'(MAX_MIN)) ? '0 : minutes + 7'd1;
    end
  end
  always_comb begin
    dval = (idx == DIG_SEC_ONES) ? 4'(seconds % 6'd10) :
           (idx == DIG_SEC_TENS) ? 4'(seconds / 6'd10) :
           (idx == DIG_MIN_ONES) ? 4'(minutes % 7'd10) : 4'(minutes / 7'd10);
    glyph = seg_of(dval);
    blank = state == ADJUST && !phase && (sel ? !idx[1] : idx[1]);
  end
`ifdef STOPWATCH_COLON_EN
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  logic [TW-1:0] colon_cnt;
  // tracks the tick prescaler so the colon is lit during the first half-second
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) colon_cnt <= '0;
    else colon_cnt <= (state != RUN || clear_pulse || tick) ? '0 : colon_cnt + TW'(1);
  assign dp = !(idx == DIG_MIN_ONES && (state != RUN || colon_cnt < TW'(TICK_DIV / 2)));
`else
  assign dp = 1'b1;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state   <= RUN;
      minutes <= '0;
      seconds <= '0;
      idx     <= DIG_SEC_ONES;
      phase   <= 1'b1;
      an      <= 4'b1111;
      seg     <= SEG_BLANK;
    end else begin
      state   <= state_nx;
      minutes <= min_nx;
      seconds <= sec_nx;
      idx     <= scan_stb ? idx + 2'd1 : idx;
      phase   <= (state != ADJUST) ? 1'b1 : blink_stb ? ~phase : phase;
      an      <= ~(4'b0001 << idx);
      seg     <= blank ? SEG_BLANK : {dp, glyph[6:0]};
    end
endmodule

// File: tb/tb_stopwatch_mmss.sv
// tb_stopwatch_mmss: directed plus randomized stimulus against a behavioural time/display model.
module tb_stopwatch_mmss;
  localparam int TD = 10, AD = 5, BD = 3, SD = 4, MX = 2;
  logic clk = 0, rst_n = 1, pause_pulse = 0, clear_pulse = 0, adj = 0, sel = 0;
  logic [3:0] an;
  logic [7:0] seg;
  logic [6:0] minutes;
  logic [5:0] seconds;
  always #5 clk = ~clk;
  stopwatch_mmss #(.TICK_DIV(TD), .ADJ_DIV(AD), .BLINK_DIV(BD), .SCAN_DIV(SD), .MAX_MIN(MX)) dut (
    .clk(clk), .rst_n(rst_n), .pause_pulse(pause_pulse), .clear_pulse(clear_pulse),
    .adj(adj), .sel(sel), .an(an), .seg(seg), .minutes(minutes), .seconds(seconds)
  );
  int nvec = 0, nmis = 0;
  bit chk_en = 0;
  int st, mm, ss, tc, ac, bc, sc, idx;
  bit ph;
  logic [3:0] e_an;
  logic [7:0] e_seg;
  logic [7:0] glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [7:0] want [4] = '{8'hB0, 8'hA4, 8'hF9, 8'hC0};
  task automatic check(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nmis++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    st = 0; mm = 0; ss = 0; tc = 0; ac = 0; bc = 0; sc = 0; idx = 0; ph = 1;
    e_an = 4'hF; e_seg = 8'hFF;
  endtask
  // st: 0 running, 1 paused, 2 adjusting
  task automatic model_step();
    bit t, a, b, s, blank;
    int d, tot;
    t = tc == TD - 1; a = ac == AD - 1; b = bc == BD - 1; s = sc == SD - 1;
    d = idx == 0 ? ss % 10 : idx == 1 ? ss / 10 : idx == 2 ? mm % 10 : mm / 10;
    blank = st == 2 && !ph && (sel ? idx < 2 : idx >= 2);
    e_an = 4'hF ^ 4'(1 << idx);
    e_seg = blank ? 8'hFF : glyph[d];
    tot = mm * 60 + ss;
    if (clear_pulse) begin
      mm = 0; ss = 0;
    end else if (st == 0 && t) begin
      tot = (tot + 1) % ((MX + 1) * 60);
      mm = tot / 60; ss = tot % 60;
    end else if (st == 2 && a) begin
      if (sel) ss = (ss + 1) % 60;
      else mm = (mm + 1) % (MX + 1);
    end
    tc = (st != 0 || clear_pulse) ? 0 : (tc + 1) % TD;
    ac = (st != 2) ? 0 : (ac + 1) % AD;
    bc = (bc + 1) % BD;
    sc = (sc + 1) % SD;
    if (s) idx = (idx + 1) % 4;
    ph = (st != 2) ? 1'b1 : (b ? !ph : ph);
    if (st == 2) st = adj ? 2 : 1;
    else if (adj) st = 2;
    else if (pause_pulse) st = (st == 0) ? 1 : 0;
  endtask
  always @(negedge clk) if (chk_en) begin
    check("minutes", minutes, mm);
    check("seconds", seconds, ss);
    check("an", an, e_an);
    check("seg", seg, e_seg);
  end
  task automatic cyc(input bit pp, input bit cp, input bit ad, input bit sl);
    pause_pulse = pp; clear_pulse = cp; adj = ad; sel = sl;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask
  task automatic run(input int n, input bit ad, input bit sl);
    repeat (n) cyc(0, 0, ad, sl);
  endtask
  task automatic chk_time(input string n, input int m, input int s);
    check({n, "_min"}, minutes, m);
    check({n, "_sec"}, seconds, s);
  endtask
  initial begin
    int nblank, cnt [4], j;
    bit ad, sl;
    model_reset();
    #1 rst_n = 0;
    #10;
    check("rst_an", an, 15);
    check("rst_seg", seg, 255);
    chk_time("rst", 0, 0);
    @(negedge clk) rst_n = 1;
    chk_en = 1;
    run(9, 0, 0);    chk_time("run9", 0, 0);
    run(1, 0, 0);    chk_time("run10", 0, 1);
    run(590, 0, 0);  chk_time("run600", 1, 0);
    run(1190, 0, 0); chk_time("run1790", 2, 59);
    run(10, 0, 0);   chk_time("wrap", 0, 0);
    run(30, 0, 0);   chk_time("pre_pause", 0, 3);
    cyc(1, 0, 0, 0);
    run(50, 0, 0);   chk_time("paused", 0, 3);
    cyc(1, 0, 0, 0);
    run(9, 0, 0);    chk_time("resume9", 0, 3);
    run(1, 0, 0);    chk_time("resume10", 0, 4);
    cyc(0, 0, 1, 1);
    run(270, 1, 1);  chk_time("adj_sec58", 0, 58);
    run(10, 1, 1);   chk_time("adj_sec_wrap", 0, 0);
    run(10, 1, 0);   chk_time("adj_min2", 2, 0);
    run(5, 1, 0);    chk_time("adj_min_wrap", 0, 0);
    nblank = 0;
    for (int i = 0; i < 24; i++) begin
      cyc(0, 0, 1, 0);
      if (!an[0] || !an[1]) check("sec_digit_unblanked", seg, 8'hC0);
      else if (seg == 8'hFF) nblank++;
    end
    check("min_digits_blinked", int'(nblank > 0), 1);
    run(2, 0, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0);
      check("paused_no_blank", int'(seg == 8'hFF), 0);
    end
    check("after_adj_held_sec", seconds, 0);
    cyc(0, 1, 0, 0); chk_time("clear_paused", 0, 0);
    cyc(0, 0, 1, 1);
    run(295, 1, 1);  chk_time("adj_to_59", 0, 59);
    run(5, 1, 0);    chk_time("adj_to_159", 1, 59);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    run(9, 0, 0);    chk_time("pre_clear", 1, 59);
    cyc(0, 1, 0, 0); chk_time("clear_vs_tick", 0, 0);
    run(10, 0, 0);   chk_time("after_clear", 0, 1);
    #2 rst_n = 0;
    chk_en = 0;
    #1;
    check("async_rst_an", an, 15);
    check("async_rst_seg", seg, 255);
    chk_time("async_rst", 0, 0);
    model_reset();
    @(negedge clk) rst_n = 1;
    chk_en = 1;
    cyc(0, 0, 1, 1);
    run(115, 1, 1);  chk_time("set_23", 0, 23);
    run(5, 1, 0);    chk_time("set_123", 1, 23);
    cyc(0, 0, 0, 0);
    run(2, 0, 0);
    cnt = '{0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 0);
      j = -1;
      for (int k = 0; k < 4; k++) if (an == (4'hF ^ 4'(1 << k))) j = k;
      check("scan_onehot", int'(j >= 0), 1);
      if (j >= 0) begin
        check("scan_seg", seg, want[j]);
        cnt[j]++;
      end
    end
    for (int k = 0; k < 4; k++) check("scan_count", cnt[k], 4);
    ad = 0; sl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) == 0) ad = !ad;
      if ($urandom_range(39) == 0) sl = !sl;
      cyc($urandom_range(24) == 0, $urandom_range(59) == 0, ad, sl);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
